fetch_prefetch_unit: RTL

Parametrised successor to the single-word fetch stage. It issues pipelined, in-order instruction-memory reads with up to MAX_OUTSTANDING requests in flight and buffers the returned words in a FIFO_DEPTH-entry prefetch queue. Decode pops that queue through a valid/ready handshake. On a redirect it flushes the queue and silently discards responses still in flight from the old stream. It sits between the instruction memory port and decode; 16-bit realignment stays downstream.

---
 rtl/fetch_prefetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Pipelined in-order instruction fetch with a prefetch queue toward decode.
// A redirect flushes the queue and drops responses still owed to the old stream.
module fetch_prefetch_unit #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  target_valid_i,
  input  logic [ADDR_WIDTH-1:0] target_addr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  imem_valid_o,
  input  logic                  imem_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned STRIDE = DATA_WIDTH / 8;
  localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned SW     = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRIDE - 1));

  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic [OW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] tgt_aligned_c, req_addr_c;
  logic                  room_c, empty_c, accept_c, push_c, pop_c;

  // Only live (non-discarded) requests reserve a queue slot.
  assign room_c        = (SW'(outstanding_q - discard_q) + SW'(count_q)) < SW'(FIFO_DEPTH);
  assign empty_c       = (count_q == '0);
  assign tgt_aligned_c = target_addr_i & ALIGN_MASK;
  assign req_addr_c    = target_valid_i ? tgt_aligned_c : fetch_addr_q;

  assign imem_valid_o  = rst_n & req_i & (outstanding_q < OW'(MAX_OUTSTANDING)) & room_c;
  assign imem_addr_o   = rst_n ? req_addr_c : '0;
  assign instr_valid_o = !empty_c & !target_valid_i;
  assign instr_o       = empty_c ? '0 : data_mem_q[rd_ptr_q];
  assign instr_addr_o  = empty_c ? '0 : addr_mem_q[rd_ptr_q];
  assign busy_o        = (outstanding_q != '0) | !empty_c;

  assign accept_c = imem_valid_o & imem_ready_i;
  assign push_c   = imem_rvalid_i & (discard_q == '0) & !target_valid_i;
  assign pop_c    = instr_valid_o & instr_ready_i;

  // Next-state: redirect overrides queue activity and re-arms the discard count.
  always_comb begin
    rsp_addr_d    = rsp_addr_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fetch_addr_d  = accept_c ? (req_addr_c + STRIDE_A) : req_addr_c;
    outstanding_d = outstanding_q + OW'(accept_c) - OW'(imem_rvalid_i);
    if (target_valid_i) begin
      discard_d  = outstanding_q - OW'(imem_rvalid_i);
      rsp_addr_d = tgt_aligned_c;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - OW'(1);
      if (push_c) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        rsp_addr_d = rsp_addr_q + STRIDE_A;
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q  <= RESET_ADDR;
      rsp_addr_q    <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      rsp_addr_q    <= rsp_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Queue storage; contents are only observable while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (push_c) begin
      data_mem_q[wr_ptr_q] <= imem_rdata_i;
      addr_mem_q[wr_ptr_q] <= rsp_addr_q;
    end
  end

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (outstanding_q != '0));

endmodule
